text_write_ctrl: RTL



---
 rtl/text_write_ctrl_if.sv | 25 ++
 rtl/text_write_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/text_write_ctrl_if.sv
// Character-stream handshake, clear request and tile RAM write port of text_write_ctrl.
// master = character source / RAM side, slave = the controller itself.
interface text_write_ctrl_if;
  logic        char_valid;
  logic [6:0]  char_data;
  logic        char_ready;
  logic        clr_req;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [6:0]  wr_data;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        busy;
  logic        cursor_vis;

  modport master (
    output char_valid, char_data, clr_req,
    input  char_ready, wr_en, wr_addr, wr_data, cur_x, cur_y, busy, cursor_vis
  );

  modport slave (
    input  char_valid, char_data, clr_req,
    output char_ready, wr_en, wr_addr, wr_data, cur_x, cur_y, busy, cursor_vis
  );
endinterface

// File: rtl/text_write_ctrl.sv
// Write-side controller for the text tile RAM: cursor tracking, CR/LF/BS/FF and clear sweeps.
// Optional cursor blinking is built when CURSOR_BLINK_EN is defined.
module text_write_ctrl #(
  parameter int unsigned MAX_X      = 80,
  parameter int unsigned MAX_Y      = 30,
  parameter logic [6:0]  BLANK_CHAR = 7'h20,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  text_write_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LINE_CLR} state_t;

  localparam logic [6:0] LAST_X = 7'(MAX_X - 1);
  localparam logic [4:0] LAST_Y = 5'(MAX_Y - 1);

  if (MAX_X > 128 || MAX_Y > 32 || MAX_X < 1 || MAX_Y < 1 || BLINK_DIV < 1) begin : g_bad_params
    $error("text_write_ctrl: illegal parameter values");
  end

  state_t      state_q, state_d;
  logic [6:0]  sweep_col_q, sweep_col_d;
  logic [4:0]  sweep_row_q, sweep_row_d;
  logic [6:0]  cur_x_q, cur_x_d;
  logic [4:0]  cur_y_q, cur_y_d;
  logic        clr_pend_q, clr_pend_d;
  logic        wr_en_q, wr_en_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [6:0]  wr_data_q, wr_data_d;
  logic        char_ready;
  logic        accept;
  logic [4:0]  next_row;

  assign char_ready = (state_q == S_IDLE) && !bus.clr_req && !clr_pend_q;
  assign accept     = bus.char_valid && char_ready;
  assign next_row   = (cur_y_q == LAST_Y) ? 5'd0 : cur_y_q + 5'd1;

  always_comb begin
    state_d     = state_q;
    sweep_col_d = sweep_col_q;
    sweep_row_d = sweep_row_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    clr_pend_d  = clr_pend_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    unique case (state_q)
      S_IDLE: begin
        // A clear request takes priority; the pending char stays unaccepted.
        if (bus.clr_req) begin
          state_d = S_CLEAR;
          cur_x_d = 7'd0;
          cur_y_d = 5'd0;
        end else if (accept) begin
          if (bus.char_data >= 7'h20 && bus.char_data <= 7'h7E) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {cur_y_q, cur_x_q};
            wr_data_d = bus.char_data;
            if (cur_x_q < LAST_X) begin
              cur_x_d = cur_x_q + 7'd1;
            end else begin
              cur_x_d = 7'd0;
              cur_y_d = next_row;
              state_d = S_LINE_CLR;
            end
          end else begin
            case (bus.char_data)
              7'h0D: cur_x_d = 7'd0;
              7'h0A: begin
                cur_x_d = 7'd0;
                cur_y_d = next_row;
                state_d = S_LINE_CLR;
              end
              7'h08: begin
                if (cur_x_q != 7'd0) begin
                  cur_x_d   = cur_x_q - 7'd1;
                  wr_en_d   = 1'b1;
                  wr_addr_d = {cur_y_q, cur_x_q - 7'd1};
                  wr_data_d = BLANK_CHAR;
                end
              end
              7'h0C: begin
                state_d = S_CLEAR;
                cur_x_d = 7'd0;
                cur_y_d = 5'd0;
              end
              default: ;
            endcase
          end
        end
      end

      S_CLEAR: begin
        cur_x_d   = 7'd0;
        cur_y_d   = 5'd0;
        wr_en_d   = 1'b1;
        wr_addr_d = {sweep_row_q, sweep_col_q};
        wr_data_d = BLANK_CHAR;
        if (sweep_col_q == LAST_X) begin
          sweep_col_d = 7'd0;
          if (sweep_row_q == LAST_Y) begin
            sweep_row_d = 5'd0;
            state_d     = S_IDLE;
          end else begin
            sweep_row_d = sweep_row_q + 5'd1;
          end
        end else begin
          sweep_col_d = sweep_col_q + 7'd1;
        end
      end

      S_LINE_CLR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {cur_y_q, sweep_col_q};
        wr_data_d = BLANK_CHAR;
        if (bus.clr_req) clr_pend_d = 1'b1;
        if (sweep_col_q == LAST_X) begin
          sweep_col_d = 7'd0;
          if (clr_pend_q || bus.clr_req) begin
            state_d    = S_CLEAR;
            clr_pend_d = 1'b0;
            cur_x_d    = 7'd0;
            cur_y_d    = 5'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          sweep_col_d = sweep_col_q + 7'd1;
        end
      end

      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_CLEAR;
      sweep_col_q <= 7'd0;
      sweep_row_q <= 5'd0;
      cur_x_q     <= 7'd0;
      cur_y_q     <= 5'd0;
      clr_pend_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 12'd0;
      wr_data_q   <= BLANK_CHAR;
    end else begin
      state_q     <= state_d;
      sweep_col_q <= sweep_col_d;
      sweep_row_q <= sweep_row_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      clr_pend_q  <= clr_pend_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          vis_q, vis_d;

  // Typing or any cursor move restarts the blink phase so the cursor stays solid.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    vis_d       = vis_q;
    if (accept || (cur_x_d != cur_x_q) || (cur_y_d != cur_y_q)) begin
      blink_cnt_d = '0;
      vis_d       = 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      vis_d       = !vis_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      vis_q       <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      vis_q       <= vis_d;
    end
  end

  assign bus.cursor_vis = vis_q && (state_q == S_IDLE);
`else
  assign bus.cursor_vis = 1'b1;
`endif

  assign bus.char_ready = char_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.cur_x      = cur_x_q;
  assign bus.cur_y      = cur_y_q;
  assign bus.busy       = (state_q != S_IDLE);
endmodule
